// File: rtl/bob_pkg.sv
// bob_pkg: shared predictor widths and the branch outcome buffer entry layout
package bob_pkg;
  localparam int PC_W = 64;
  localparam int BHR_W = 12;
  localparam int LH_W = 10;
  localparam int BOB_DEPTH = 16;
  localparam int BOB_TAG_W = $clog2(BOB_DEPTH);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [BHR_W-1:0] bhr;
    logic [LH_W-1:0] lochist;
    logic pred;
    logic ch_we;
    logic ch_ud;
  } bob_entry_t;
endpackage

// File: rtl/bob_ram.sv
// bob_ram: entry storage, one write port and one combinational read port
module bob_ram
  import bob_pkg::*;
#(
  parameter int DEPTH = BOB_DEPTH,
  parameter int AW = BOB_TAG_W
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  bob_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output bob_entry_t    rdata_o
);
  bob_entry_t mem_q [DEPTH];
  // write the newly allocated entry; contents need no reset
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/bob.sv
// bob: branch outcome buffer replaying fetch-time predictor state at retirement
module bob
  import bob_pkg::*;
#(
  parameter int DEPTH = BOB_DEPTH,
  parameter int TAG_W = BOB_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_valid_i,
  input  logic [PC_W-1:0]  alloc_pc_i,
  input  logic [BHR_W-1:0] alloc_bhr_i,
  input  logic [LH_W-1:0]  alloc_lochist_i,
  input  logic             alloc_pred_i,
  input  logic             alloc_ch_we_i,
  input  logic             alloc_ch_ud_i,
  output logic             alloc_ready_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             retire_valid_i,
  input  logic             retire_brdir_i,
  input  logic             flush_i,
  output logic [PC_W-1:0]  bob_pc_r_o,
  output logic [BHR_W-1:0] bob_bhr_r_o,
  output logic [LH_W-1:0]  bob_lochist_o,
  output logic             bob_valid_r_o,
  output logic             bpd_rt_we_o,
  output logic             bpd_rt_update_o,
  output logic             bpd_rt_brdir_o,
  output logic             bpd_ch_we_o,
  output logic             bpd_ch_brdir_o,
  output logic             mispredict_o,
  output logic [TAG_W:0]   count_o,
  output logic             underflow_o
);
  localparam logic [TAG_W:0] FULL = (TAG_W + 1)'(DEPTH);
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0] count_q, count_d;
  logic alloc_ok, ret_ok, mis, clr, wr_en, valid_q, mis_q, under_q;
  bob_entry_t wr_e, rd_e;
  logic [PC_W-1:0] pc_q;
  logic [BHR_W-1:0] bhr_q;
  logic [LH_W-1:0] lh_q;
  logic brdir_q, ch_we_q, ch_ud_q;
  assign wr_e = '{pc: alloc_pc_i, bhr: alloc_bhr_i, lochist: alloc_lochist_i,
                  pred: alloc_pred_i, ch_we: alloc_ch_we_i, ch_ud: alloc_ch_ud_i};
  assign alloc_ready_o = count_q != FULL;
  assign alloc_tag_o = tail_q;
  assign count_o = count_q;
  // a wrong-path retire or a flush squashes everything younger, including a same-cycle alloc
  always_comb begin
    alloc_ok = alloc_valid_i && (count_q != FULL);
    ret_ok = retire_valid_i && (count_q != '0);
    mis = ret_ok && (rd_e.pred ^ retire_brdir_i);
    clr = flush_i || mis;
    wr_en = alloc_ok && !clr;
    head_d = clr ? '0 : head_q + TAG_W'(ret_ok);
    tail_d = clr ? '0 : tail_q + TAG_W'(alloc_ok);
    count_d = clr ? '0 : count_q + (TAG_W + 1)'(alloc_ok) - (TAG_W + 1)'(ret_ok);
  end
  // pointer and occupancy state
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  // retire outputs: strobes pulse for one cycle, data fields hold until the next retire
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      valid_q <= 1'b0;
      mis_q <= 1'b0;
      under_q <= 1'b0;
      pc_q <= '0;
      bhr_q <= '0;
      lh_q <= '0;
      brdir_q <= 1'b0;
      ch_we_q <= 1'b0;
      ch_ud_q <= 1'b0;
    end else begin
      valid_q <= ret_ok;
      mis_q <= mis;
      under_q <= under_q || (retire_valid_i && count_q == '0);
      if (ret_ok) begin
        pc_q <= rd_e.pc;
        bhr_q <= rd_e.bhr;
        lh_q <= rd_e.lochist;
        brdir_q <= retire_brdir_i;
        ch_we_q <= rd_e.ch_we;
        ch_ud_q <= rd_e.ch_ud;
      end
    end
  assign bob_valid_r_o = valid_q;
  assign bpd_rt_we_o = valid_q;
  assign bpd_rt_update_o = valid_q;
  assign mispredict_o = mis_q;
  assign underflow_o = under_q;
  assign bob_pc_r_o = pc_q;
  assign bob_bhr_r_o = bhr_q;
  assign bob_lochist_o = lh_q;
  assign bpd_rt_brdir_o = brdir_q;
  assign bpd_ch_we_o = ch_we_q;
  assign bpd_ch_brdir_o = ch_ud_q;
  bob_ram #(.DEPTH(DEPTH), .AW(TAG_W)) u_ram (
    .clk_i(clock),
    .we_i(wr_en),
    .waddr_i(tail_q),
    .wdata_i(wr_e),
    .raddr_i(head_q),
    .rdata_o(rd_e)
  );
endmodule

// File: tb/tb_bob.sv
// tb_bob: scoreboard bench for the branch outcome buffer
module tb_bob;
  import bob_pkg::*;
  typedef struct packed {
    bob_entry_t e;
    logic brdir;
    logic mis;
  } exp_t;
  logic clock = 1'b0, reset = 1'b1;
  logic alloc_valid_i = 1'b0, alloc_pred_i = 1'b0, alloc_ch_we_i = 1'b0, alloc_ch_ud_i = 1'b0;
  logic [63:0] alloc_pc_i = '0;
  logic [11:0] alloc_bhr_i = '0;
  logic [9:0] alloc_lochist_i = '0;
  logic retire_valid_i = 1'b0, retire_brdir_i = 1'b0, flush_i = 1'b0;
  logic alloc_ready_o, bob_valid_r_o, bpd_rt_we_o, bpd_rt_update_o, bpd_rt_brdir_o;
  logic bpd_ch_we_o, bpd_ch_brdir_o, mispredict_o, underflow_o;
  logic [3:0] alloc_tag_o;
  logic [63:0] bob_pc_r_o;
  logic [11:0] bob_bhr_r_o;
  logic [9:0] bob_lochist_o;
  logic [4:0] count_o;
  int checks = 0, failures = 0;
  bob_entry_t m_q[$];
  exp_t x_q[$];
  logic m_under = 1'b0;
  logic [3:0] m_tail = '0;
  logic [63:0] last_pc = '0;

  bob dut (
    .clock(clock), .reset(reset),
    .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i), .alloc_bhr_i(alloc_bhr_i),
    .alloc_lochist_i(alloc_lochist_i), .alloc_pred_i(alloc_pred_i),
    .alloc_ch_we_i(alloc_ch_we_i), .alloc_ch_ud_i(alloc_ch_ud_i),
    .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
    .retire_valid_i(retire_valid_i), .retire_brdir_i(retire_brdir_i), .flush_i(flush_i),
    .bob_pc_r_o(bob_pc_r_o), .bob_bhr_r_o(bob_bhr_r_o), .bob_lochist_o(bob_lochist_o),
    .bob_valid_r_o(bob_valid_r_o), .bpd_rt_we_o(bpd_rt_we_o), .bpd_rt_update_o(bpd_rt_update_o),
    .bpd_rt_brdir_o(bpd_rt_brdir_o), .bpd_ch_we_o(bpd_ch_we_o), .bpd_ch_brdir_o(bpd_ch_brdir_o),
    .mispredict_o(mispredict_o), .count_o(count_o), .underflow_o(underflow_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bob_entry_t mk(input logic [63:0] pc, input logic [11:0] bhr,
                                     input logic [9:0] lh, input logic pred);
    bob_entry_t e;
    e.pc = pc;
    e.bhr = bhr;
    e.lochist = lh;
    e.pred = pred;
    e.ch_we = 1'($urandom);
    e.ch_ud = 1'($urandom);
    return e;
  endfunction

  function automatic bob_entry_t rnd();
    return mk({$urandom, $urandom}, 12'($urandom), 10'($urandom), 1'($urandom));
  endfunction

  function automatic logic front_pred();
    return m_q.size() != 0 ? m_q[0].pred : 1'b0;
  endfunction

  // one clock: drive, update the model, then check registered results after the edge
  task automatic cyc(input logic av, input bob_entry_t e, input logic rv, input logic brdir,
                     input logic fl);
    logic pushed, ret_ok, alloc_ok, mis;
    exp_t x;
    alloc_valid_i = av;
    alloc_pc_i = e.pc;
    alloc_bhr_i = e.bhr;
    alloc_lochist_i = e.lochist;
    alloc_pred_i = e.pred;
    alloc_ch_we_i = e.ch_we;
    alloc_ch_ud_i = e.ch_ud;
    retire_valid_i = rv;
    retire_brdir_i = brdir;
    flush_i = fl;
    #1;
    chk("alloc_ready", alloc_ready_o, m_q.size() != 16);
    if (av) chk("alloc_tag", alloc_tag_o, m_tail);
    alloc_ok = av && m_q.size() != 16;
    ret_ok = rv && m_q.size() != 0;
    mis = 1'b0;
    pushed = 1'b0;
    if (rv && m_q.size() == 0) m_under = 1'b1;
    if (ret_ok) begin
      x.e = m_q.pop_front();
      x.brdir = brdir;
      x.mis = x.e.pred ^ brdir;
      mis = x.mis;
      x_q.push_back(x);
      pushed = 1'b1;
    end
    if (fl || mis) begin
      m_q.delete();
      m_tail = '0;
    end else if (alloc_ok) begin
      m_q.push_back(e);
      m_tail++;
    end
    @(posedge clock);
    #1;
    chk("valid", bob_valid_r_o, pushed);
    chk("rt_we", bpd_rt_we_o, pushed);
    chk("rt_update", bpd_rt_update_o, pushed);
    if (bob_valid_r_o && x_q.size() != 0) begin
      x = x_q.pop_front();
      chk("ret_pc", bob_pc_r_o, x.e.pc);
      chk("ret_bhr", bob_bhr_r_o, 64'(x.e.bhr));
      chk("ret_lochist", bob_lochist_o, 64'(x.e.lochist));
      chk("ret_ch_we", bpd_ch_we_o, x.e.ch_we);
      chk("ret_ch_brdir", bpd_ch_brdir_o, x.e.ch_ud);
      chk("ret_brdir", bpd_rt_brdir_o, x.brdir);
      chk("mispredict", mispredict_o, x.mis);
      last_pc = x.e.pc;
    end else begin
      chk("mispredict_idle", mispredict_o, 1'b0);
      chk("hold_pc", bob_pc_r_o, last_pc);
    end
    chk("pending", x_q.size(), 0);
    x_q.delete();
    chk("count", count_o, m_q.size());
    chk("underflow", underflow_o, m_under);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_ready"}, alloc_ready_o, 1);
    chk({tag, "_tag"}, alloc_tag_o, 0);
    chk({tag, "_strobes"}, {bob_valid_r_o, bpd_rt_we_o, bpd_rt_update_o, mispredict_o, underflow_o}, 0);
    chk({tag, "_data"}, bob_pc_r_o | 64'(bob_bhr_r_o) | 64'(bob_lochist_o), 0);
    chk({tag, "_bits"}, {bpd_rt_brdir_o, bpd_ch_we_o, bpd_ch_brdir_o}, 0);
  endtask

  bob_entry_t idle = '0;

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;
    // three allocs with known PC/BHR
    for (int i = 0; i < 3; i++)
      cyc(1'b1, mk(64'h1000 + 64'(4 * i), 12'((1 << (i + 1)) - 1), 10'($urandom), 1'b1), 1'b0, 1'b0, 1'b0);
    // correct retire of entry 0
    cyc(1'b0, idle, 1'b1, 1'b1, 1'b0);
    chk("first_pc", bob_pc_r_o, 64'h1000);
    chk("first_bhr", bob_bhr_r_o, 64'h001);
    // fill to full
    while (m_q.size() < 16) cyc(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    chk("full_ready", alloc_ready_o, 1'b0);
    // alloc while full with a retire: alloc rejected, count drops to 15
    cyc(1'b1, rnd(), 1'b1, front_pred(), 1'b0);
    chk("full_reject", count_o, 15);
    // mixed traffic past the tag wrap, always predicted correctly
    for (int i = 0; i < 30; i++) begin
      logic r;
      r = 1'($urandom);
      cyc(1'($urandom), rnd(), r, front_pred(), 1'b0);
    end
    // mispredict with a random front entry, same-cycle alloc discarded
    if (m_q.size() == 0) cyc(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b1, ~front_pred(), 1'b0);
    // pred=1 retired with brdir=0
    cyc(1'b1, mk(64'h2000, 12'h0ff, 10'h155, 1'b1), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b1, 1'b0, 1'b0);
    chk("mis_flag", mispredict_o, 1'b1);
    chk("mis_brdir", bpd_rt_brdir_o, 1'b0);
    chk("mis_clear", count_o, 0);
    // flush together with a correct retire
    cyc(1'b1, mk(64'h3000, 12'h0a0, 10'h2a5, 1'b0), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b1, 1'b0, 1'b1);
    chk("flush_lochist", bob_lochist_o, 64'h2a5);
    chk("flush_clear", count_o, 0);
    // retire while empty: underflow is sticky
    cyc(1'b0, idle, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, idle, 1'b0, 1'b0, 1'b0);
    chk("underflow_sticky", underflow_o, 1'b1);
    cyc(1'b1, rnd(), 1'b1, 1'b0, 1'b0);
    // async reset mid-stream with five entries
    while (m_q.size() < 5) cyc(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    alloc_valid_i = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clock);
    #1 reset = 1'b0;
    m_q.delete();
    m_tail = '0;
    m_under = 1'b0;
    last_pc = '0;
    // recovery after reset
    for (int i = 0; i < 4; i++) cyc(1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, idle, 1'b1, front_pred(), 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end
endmodule

// File: doc/bob.md
Name: bob

Overview:
- Branch outcome buffer: a circular FIFO that records fetch-time predictor state for every conditional branch predicted in fetch stage F1.
- Replays that state in program order at retirement, so the tournament predictor gets a non-speculative update: choice PHT, local BHT, local and global PHTs.
- Drives the history-recovery inputs used when the global history register (BHR) is repaired after a mispredict.
- Sits between fetch (producer, alloc side) and the commit/retire logic (consumer, retire side).

Parameters:
- DEPTH, 16: number of in-flight branch entries; must be a power of 2, at least 2.
- TAG_W, 4: log2(DEPTH); width of the entry tag.
- BHR_W, 12: global history width.
- LH_W, 10: local history width.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- alloc_valid_i, input, 1: F1 conditional branch is predicted and the fetch pipe advances this cycle.
- alloc_pc_i, input, 64: PC of the branch.
- alloc_bhr_i, input, BHR_W: speculative BHR before this branch is shifted in.
- alloc_lochist_i, input, LH_W: local history read in F1.
- alloc_pred_i, input, 1: final predicted direction.
- alloc_ch_we_i, input, 1: choice-update enable (global prediction XOR local prediction).
- alloc_ch_ud_i, input, 1: local prediction, used for the choice-update direction.
- alloc_ready_o, output, 1: buffer not full.
- alloc_tag_o, output, TAG_W: tail index assigned to an alloc this cycle.
- retire_valid_i, input, 1: oldest conditional branch commits this cycle.
- retire_brdir_i, input, 1: actual resolved direction.
- flush_i, input, 1: pipeline flush from exception or redirect.
- bob_pc_r_o, output, 64: PC of the retired entry.
- bob_bhr_r_o, output, BHR_W: BHR of the retired entry.
- bob_lochist_o, output, LH_W: local history of the retired entry.
- bob_valid_r_o, output, 1: the retire outputs above are valid this cycle.
- bpd_rt_we_o, output, 1: BHT update write enable.
- bpd_rt_update_o, output, 1: PHT update write enable.
- bpd_rt_brdir_o, output, 1: actual direction.
- bpd_ch_we_o, output, 1: stored choice-update enable.
- bpd_ch_brdir_o, output, 1: stored local prediction.
- mispredict_o, output, 1: retired entry's prediction differed from the actual direction.
- count_o, output, TAG_W+1: occupancy.
- underflow_o, output, 1: sticky flag, set when retire is asserted while empty.

Behaviour:
- Storage: head_ptr, tail_ptr (TAG_W bits, wrap modulo DEPTH) and count (TAG_W+1 bits).
  - Per-entry fields: pc, bhr, lochist, pred, ch_we, ch_ud.
- Reset (async, active-high):
  - Pointers and count go to 0.
  - All outputs go to 0; alloc_ready_o = 1.
  - Entry contents are don't-care.
- Alloc:
  - Accepted when alloc_valid_i && count != DEPTH; alloc_ready_o = (count != DEPTH), combinational from count.
  - Write the entry at tail_ptr; alloc_tag_o = tail_ptr; tail_ptr increments by 1, wrapping.
  - Alloc while full is dropped with no state change; upstream must stall.
- Retire:
  - Accepted when retire_valid_i && count != 0; reads the entry at head_ptr and increments head_ptr.
  - Outputs are registered and appear in the cycle after retire_valid_i, as a 1-cycle pulse:
    - bob_valid_r_o = bpd_rt_we_o = bpd_rt_update_o = 1.
    - bpd_rt_brdir_o = retire_brdir_i.
    - bob_pc_r_o, bob_bhr_r_o, bob_lochist_o, bpd_ch_we_o, bpd_ch_brdir_o come from the entry.
    - mispredict_o = pred ^ retire_brdir_i.
  - In cycles with no retire: valid, we, update and mispredict outputs = 0; data outputs hold their last value.
  - Retire while empty: ignored, underflow_o set to 1 and held until reset.
- Mispredict at retire: all younger entries are wrong-path.
  - The next state clears the buffer: head = tail = 0, count = 0.
  - Any alloc in that same cycle is discarded.
- flush_i:
  - A retire in the same cycle is still performed, and its outputs are still emitted.
  - The buffer is then cleared: pointers and count go to 0, and any same-cycle alloc is discarded.
- Simultaneous alloc and retire with no flush and no mispredict: count unchanged; full or empty status evaluated on the pre-cycle count.
  - So alloc while full is rejected even if a retire happens in the same cycle.
- Count:
  - count_next = count + accepted_alloc - accepted_retire, or 0 on clear.
  - count never exceeds DEPTH.
- BHR and local-history values are stored and replayed verbatim; no arithmetic is applied to them.

Decomposition:
- Shared predictor package holds BHR_W, LH_W, PC_W=64, and a packed entry struct {pc, bhr, lochist, pred, ch_we, ch_ud}.
- One natural sub-module, bob_ram: DEPTH x entry register array with one write port and one combinational read port, no reset on data.
- Pointer, count and output-register logic stay in bob.

Test Plan:
- Reset, then alloc 3 entries (PC 0x1000/0x1004/0x1008, bhr 0x001/0x003/0x007) -> count_o=3, tags 0,1,2, alloc_ready_o=1.
- Retire entry 0 with brdir equal to pred=1 -> next cycle bob_valid_r_o=1, bob_pc_r_o=0x1000, bob_bhr_r_o=0x001, mispredict_o=0, count_o=2.
- Fill to 16 -> alloc_ready_o=0; a 17th alloc with simultaneous retire is rejected, count_o stays 15 after the retire; continue alloc and retire past tag 15 -> tail wraps to 0, FIFO order preserved.
- Entry with pred=1 retired with brdir=0 and a same-cycle alloc -> mispredict_o=1, bpd_rt_brdir_o=0, count_o=0, alloc discarded.
- flush_i together with retire of entry lochist=0x2A5 -> bob_lochist_o=0x2A5, valid pulse is emitted, buffer empty afterwards.
- Retire while empty -> no valid pulse, underflow_o=1 and sticky; assert reset mid-stream with count=5 -> count_o=0, all outputs 0 asynchronously.
